operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Upstream neighbour of the address/ALU stage in the 6502 core.
- On a start from decode, fetches 0-2 operand bytes from a byte-wide memory port, assembles them with X/Y per addressing mode, and issues {op_A, op_B, alu_op} to the ALU as a one-cycle valid pulse.
- Also reports operand byte count so the PC can advance.

Parameters:
- none; widths fixed by 6502 (8-bit data, 16-bit address)

Ports:
- clk_i  in  1  core clock
- rstn_i  in  1  reset; one clock, reset is asynchronous and active-low
- start_i  in  1  decode requests operand fetch (accepted only when busy_o=0)
- addr_mode_i  in  3  addr_mode_t, sampled with start_i
- pc_i  in  16  address of first operand byte, sampled with start_i
- x_i  in  8  X register, sampled with start_i
- y_i  in  8  Y register, sampled with start_i
- mem_req_o  out  1  read request
- mem_addr_o  out  16  read address
- mem_rvalid_i  in  1  read data valid (same cycle as req or later)
- mem_rdata_i  in  8  read data
- busy_o  out  1  state != IDLE
- op_valid_o  out  1  one-cycle pulse; operands valid
- op_A_o  out  16  ALU operand A
- op_B_o  out  16  ALU operand B
- alu_op_o  out  alu_op_t  ALU operation
- bytes_o  out  2  operand bytes consumed (0/1/2)

Behaviour:
- Reset: state IDLE; mem_req_o=0, mem_addr_o=0, op_valid_o=0, op_A_o=0, op_B_o=0, alu_op_o=ALU_BYPASS_A, bytes_o=0, busy_o=0. Reset mid-fetch abandons the transaction; no issue follows.
- FSM IDLE -> FETCH_LO -> [FETCH_HI] -> ISSUE -> IDLE.
  - IMPLIED goes IDLE -> ISSUE directly.
- IDLE: start_i=1 captures mode/pc/x/y. start_i while busy_o=1 is ignored (not queued).
- FETCH_LO: mem_req_o=1, mem_addr_o=pc. Held until mem_rvalid_i=1; byte captured as b0.
  - 2-byte modes go to FETCH_HI; otherwise ISSUE.
- FETCH_HI: mem_req_o=1, mem_addr_o=pc+1 (16-bit wrap, FFFF->0000). On rvalid capture b1, go to ISSUE.
- mem_rvalid_i outside FETCH states is ignored.
- ISSUE: op_valid_o=1 for exactly one cycle, then IDLE. op_A_o/op_B_o/alu_op_o/bytes_o are registered and hold until the next ISSUE.
- Mode mapping (A, B, op, bytes):
  - IMPLIED: 0, 0, BYPASS_A, 0
  - IMMEDIATE: {00,b0}, 0, BYPASS_A, 1
  - ZEROPAGE: {00,b0}, 0, BYPASS_A, 1
  - ZEROPAGE_X: {00,b0}, {00,x}, ADD_ZEROPAGE, 1
  - ABSOLUTE: {b1,b0}, 0, BYPASS_A, 2
  - ABSOLUTE_X: {b1,b0}, {00,x}, ADD, 2
  - ABSOLUTE_Y: {b1,b0}, {00,y}, ADD, 2
  - Undefined encodings: treated as IMPLIED.
- Latency with zero-wait memory (start sampled at edge 0): implied issues in cycle 1, 1-byte modes in cycle 2, 2-byte modes in cycle 3. Each wait cycle adds one.

Optional Feature:
- Macro OPFETCH_PAGE_CROSS_EN.
- Defined: adds output page_cross_o (1 bit), reset 0, registered at ISSUE. It is 1 when mode is ABSOLUTE_X/Y and (b0 + index) carries out of bit 7 (high byte of sum != b1); 0 otherwise. Used by the sequencer for the extra 6502 cycle.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- addr_mode_t (3-bit enum, encodings IMPLIED=0 ... ABSOLUTE_Y=6) goes in the ISA package.
- alu_op_t, byte-width macro and state enum (fetch_state_t) go in the core package.
- One natural sub-module: operand_map, a combinational mode/b0/b1/x/y -> {A, B, op, bytes, page_cross}. The FSM and registers stay in operand_fetch.

Test Plan:
- IMPLIED start, pc=0200 -> no mem_req; cycle 1 op_valid=1, A=0000, B=0000, BYPASS_A, bytes=0.
- IMMEDIATE pc=8000, rdata=5A, zero-wait -> req addr 8000 in cycle 1; cycle 2 op_valid, A=005A, bytes=1.
- ZEROPAGE_X b0=F0, x=20 -> A=00F0, B=0020, ADD_ZEROPAGE, bytes=1.
- ABSOLUTE_Y pc=FFFF, bytes 34 then 12, y=05, 2 wait cycles per read -> addrs FFFF then 0000; A=1234, B=0005, ADD, bytes=2; op_valid in cycle 7. start_i pulsed in cycle 3 is ignored.
- ABSOLUTE_X b0=FF, b1=10, x=01 with OPFETCH_PAGE_CROSS_EN -> page_cross_o=1. Repeat with b0=10 -> page_cross_o=0.
- rstn_i low during FETCH_HI -> mem_req_o drops immediately, all outputs return to reset values, no op_valid. A fresh start after release completes normally.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared types for the 6502 operand fetch stage: addressing modes, ALU ops,
// fetch FSM states and the mode -> operand byte count helper.
package operand_fetch_pkg;

    localparam int BYTE_W = 8;
    localparam int ADDR_W = 16;

    typedef enum logic [2:0] {
        AM_IMPLIED    = 3'd0,
        AM_IMMEDIATE  = 3'd1,
        AM_ZEROPAGE   = 3'd2,
        AM_ZEROPAGE_X = 3'd3,
        AM_ABSOLUTE   = 3'd4,
        AM_ABSOLUTE_X = 3'd5,
        AM_ABSOLUTE_Y = 3'd6
    } addr_mode_t;

    typedef enum logic [1:0] {
        ALU_BYPASS_A     = 2'd0,
        ALU_ADD          = 2'd1,
        ALU_ADD_ZEROPAGE = 2'd2
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FETCH_LO = 2'd1,
        ST_FETCH_HI = 2'd2,
        ST_ISSUE    = 2'd3
    } fetch_state_t;

    // Unused encodings fall into the default arm and behave as implied.
    function automatic logic [1:0] operand_bytes(input addr_mode_t mode);
        case (mode)
            AM_IMMEDIATE, AM_ZEROPAGE, AM_ZEROPAGE_X: return 2'd1;
            AM_ABSOLUTE, AM_ABSOLUTE_X, AM_ABSOLUTE_Y: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Byte-wide read port between the operand fetch stage (master) and memory (slave).
interface operand_fetch_if;
    import operand_fetch_pkg::*;

    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_rvalid_i;
    logic [BYTE_W-1:0] mem_rdata_i;

    modport master (output mem_req_o, mem_addr_o, input mem_rvalid_i, mem_rdata_i);
    modport slave  (input mem_req_o, mem_addr_o, output mem_rvalid_i, mem_rdata_i);
endinterface

// File: rtl/operand_fetch_map.sv
// Combinational addressing-mode decode: mode/b0/b1/x/y -> {A, B, alu op, byte count}.
// OPFETCH_PAGE_CROSS_EN adds the indexed-absolute page-crossing flag.
module operand_map
    import operand_fetch_pkg::*;
(
    input  addr_mode_t        i_mode,
    input  logic [BYTE_W-1:0] i_b0,
    input  logic [BYTE_W-1:0] i_b1,
    input  logic [BYTE_W-1:0] i_x,
    input  logic [BYTE_W-1:0] i_y,
    output logic [ADDR_W-1:0] o_op_a,
    output logic [ADDR_W-1:0] o_op_b,
    output alu_op_t           o_alu_op,
    output logic [1:0]        o_bytes
`ifdef OPFETCH_PAGE_CROSS_EN
    ,
    output logic              o_page_cross
`endif
);
    logic [ADDR_W-1:0] w_zp;
    logic [ADDR_W-1:0] w_abs;
    logic [BYTE_W-1:0] w_index;

    assign w_zp    = {{BYTE_W{1'b0}}, i_b0};
    assign w_abs   = {i_b1, i_b0};
    assign w_index = (i_mode == AM_ABSOLUTE_Y) ? i_y : i_x;

    always_comb begin
        o_op_a   = '0;
        o_op_b   = '0;
        o_alu_op = ALU_BYPASS_A;
        o_bytes  = operand_bytes(i_mode);
        case (i_mode)
            AM_IMMEDIATE, AM_ZEROPAGE: o_op_a = w_zp;
            AM_ZEROPAGE_X: begin
                o_op_a   = w_zp;
                o_op_b   = {{BYTE_W{1'b0}}, w_index};
                o_alu_op = ALU_ADD_ZEROPAGE;
            end
            AM_ABSOLUTE: o_op_a = w_abs;
            AM_ABSOLUTE_X, AM_ABSOLUTE_Y: begin
                o_op_a   = w_abs;
                o_op_b   = {{BYTE_W{1'b0}}, w_index};
                o_alu_op = ALU_ADD;
            end
            default: ;
        endcase
    end

`ifdef OPFETCH_PAGE_CROSS_EN
    // A carry out of the low byte means the effective address left b1's page.
    assign o_page_cross = ((i_mode == AM_ABSOLUTE_X) || (i_mode == AM_ABSOLUTE_Y)) &&
                          (({1'b0, i_b0} + {1'b0, w_index}) > 9'h0FF);
`endif

endmodule

// File: rtl/operand_fetch.sv
// 6502 operand fetch: reads 0-2 operand bytes, builds ALU operands and issues a
// one-cycle valid pulse. Optional page-cross output under OPFETCH_PAGE_CROSS_EN.
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              start_i,
    input  addr_mode_t        addr_mode_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [BYTE_W-1:0] x_i,
    input  logic [BYTE_W-1:0] y_i,
    operand_fetch_if.master   mem_bus,
    output logic              busy_o,
    output logic              op_valid_o,
    output logic [ADDR_W-1:0] op_A_o,
    output logic [ADDR_W-1:0] op_B_o,
    output alu_op_t           alu_op_o,
    output logic [1:0]        bytes_o
`ifdef OPFETCH_PAGE_CROSS_EN
    ,
    output logic              page_cross_o
`endif
);
    fetch_state_t      r_state, w_state_next;
    addr_mode_t        r_mode, w_mode;
    logic [ADDR_W-1:0] r_pc;
    logic [BYTE_W-1:0] r_x, r_y, r_b0, w_b0;
    logic [ADDR_W-1:0] r_op_a, r_op_b, w_op_a, w_op_b;
    alu_op_t           r_alu_op, w_alu_op;
    logic [1:0]        r_bytes, w_bytes;
    logic              w_load;
`ifdef OPFETCH_PAGE_CROSS_EN
    logic              r_page_cross, w_page_cross;
`endif

    // The map is evaluated on the cycle that enters ISSUE, so the byte arriving
    // that cycle is taken straight from the bus (b1 is never stored).
    assign w_mode = (r_state == ST_IDLE) ? addr_mode_i : r_mode;
    assign w_b0   = (r_state == ST_FETCH_LO) ? mem_bus.mem_rdata_i : r_b0;

    operand_map u_map (
        .i_mode       (w_mode),
        .i_b0         (w_b0),
        .i_b1         (mem_bus.mem_rdata_i),
        .i_x          (r_x),
        .i_y          (r_y),
        .o_op_a       (w_op_a),
        .o_op_b       (w_op_b),
        .o_alu_op     (w_alu_op),
        .o_bytes      (w_bytes)
`ifdef OPFETCH_PAGE_CROSS_EN
        ,
        .o_page_cross (w_page_cross)
`endif
    );

    always_comb begin
        w_state_next       = r_state;
        w_load             = 1'b0;
        mem_bus.mem_req_o  = 1'b0;
        mem_bus.mem_addr_o = '0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    if (operand_bytes(addr_mode_i) == 2'd0) begin
                        w_state_next = ST_ISSUE;
                        w_load       = 1'b1;
                    end else begin
                        w_state_next = ST_FETCH_LO;
                    end
                end
            end
            ST_FETCH_LO: begin
                mem_bus.mem_req_o  = 1'b1;
                mem_bus.mem_addr_o = r_pc;
                if (mem_bus.mem_rvalid_i) begin
                    if (operand_bytes(r_mode) == 2'd2) begin
                        w_state_next = ST_FETCH_HI;
                    end else begin
                        w_state_next = ST_ISSUE;
                        w_load       = 1'b1;
                    end
                end
            end
            ST_FETCH_HI: begin
                mem_bus.mem_req_o  = 1'b1;
                mem_bus.mem_addr_o = r_pc + 16'd1;
                if (mem_bus.mem_rvalid_i) begin
                    w_state_next = ST_ISSUE;
                    w_load       = 1'b1;
                end
            end
            ST_ISSUE: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state      <= ST_IDLE;
            r_mode       <= AM_IMPLIED;
            r_pc         <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_b0         <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_alu_op     <= ALU_BYPASS_A;
            r_bytes      <= '0;
`ifdef OPFETCH_PAGE_CROSS_EN
            r_page_cross <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            if ((r_state == ST_IDLE) && start_i) begin
                r_mode <= addr_mode_i;
                r_pc   <= pc_i;
                r_x    <= x_i;
                r_y    <= y_i;
            end
            if ((r_state == ST_FETCH_LO) && mem_bus.mem_rvalid_i) begin
                r_b0 <= mem_bus.mem_rdata_i;
            end
            if (w_load) begin
                r_op_a       <= w_op_a;
                r_op_b       <= w_op_b;
                r_alu_op     <= w_alu_op;
                r_bytes      <= w_bytes;
`ifdef OPFETCH_PAGE_CROSS_EN
                r_page_cross <= w_page_cross;
`endif
            end
        end
    end

    assign busy_o     = (r_state != ST_IDLE);
    assign op_valid_o = (r_state == ST_ISSUE);
    assign op_A_o     = r_op_a;
    assign op_B_o     = r_op_b;
    assign alu_op_o   = r_alu_op;
    assign bytes_o    = r_bytes;
`ifdef OPFETCH_PAGE_CROSS_EN
    assign page_cross_o = r_page_cross;
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed vector table, hand-written
// reset/busy sequences and randomized transactions against a reference model.
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    addr_mode_t mode_in = AM_IMPLIED;
    logic [15:0] pc_in = 16'h0;
    logic [7:0]  x_in = 8'h0;
    logic [7:0]  y_in = 8'h0;
    logic        busy, op_valid;
    logic [15:0] op_a, op_b;
    alu_op_t     alu_op;
    logic [1:0]  nbytes;
`ifdef OPFETCH_PAGE_CROSS_EN
    logic        page_cross;
`endif

    operand_fetch_if mif();

    operand_fetch dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .start_i     (start),
        .addr_mode_i (mode_in),
        .pc_i        (pc_in),
        .x_i         (x_in),
        .y_i         (y_in),
        .mem_bus     (mif),
        .busy_o      (busy),
        .op_valid_o  (op_valid),
        .op_A_o      (op_a),
        .op_B_o      (op_b),
        .alu_op_o    (alu_op),
        .bytes_o     (nbytes)
`ifdef OPFETCH_PAGE_CROSS_EN
        ,
        .page_cross_o(page_cross)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: answers a request after wait_cfg stall cycles; spur drives
    // stray rvalid while no request is pending.
    logic [7:0] mem_arr [0:65535];
    int         wait_cfg = 0;
    int         wcnt = 0;
    logic       spur = 1'b0;
    logic [7:0] junk = 8'h00;

    assign mif.mem_rvalid_i = mif.mem_req_o ? (wcnt >= wait_cfg) : spur;
    assign mif.mem_rdata_i  = mif.mem_req_o ? mem_arr[mif.mem_addr_o] : junk;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) wcnt <= 0;
        else if (!mif.mem_req_o || mif.mem_rvalid_i) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input string what, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h, expected %0h", tag, what, got, exp);
        end
    endtask

    // Results of the last transaction
    int          got_lat, got_vcnt;
    logic [15:0] got_a, got_b, hold_a;
    alu_op_t     got_op;
    logic [1:0]  got_bytes;
    logic        got_pc, got_busy_after;
    logic [15:0] rd_addr[$];

    // Call at posedge+1; start is sampled at the next edge (edge 0).
    task automatic run_txn(input addr_mode_t m, input logic [15:0] pc, input logic [7:0] x, input logic [7:0] y,
                           input int waits, input int pulse_at);
        wait_cfg = waits;
        got_lat = -1; got_vcnt = 0; got_busy_after = 1'b1; got_pc = 1'b0;
        got_a = 16'hxxxx; got_b = 16'hxxxx; hold_a = 16'hxxxx; got_bytes = 2'bxx; got_op = ALU_BYPASS_A;
        rd_addr.delete();
        start = 1'b1; mode_in = m; pc_in = pc; x_in = x; y_in = y;
        @(posedge clk); #1;
        mode_in = addr_mode_t'(3'($urandom_range(0, 7)));
        pc_in = 16'($urandom); x_in = 8'($urandom); y_in = 8'($urandom);
        for (int c = 1; c <= 40; c++) begin
            start = (c == pulse_at);
            @(negedge clk);
            if (mif.mem_req_o && mif.mem_rvalid_i) rd_addr.push_back(mif.mem_addr_o);
            if (op_valid) begin
                got_vcnt++;
                if (got_lat < 0) begin
                    got_lat = c; got_a = op_a; got_b = op_b; got_op = alu_op; got_bytes = nbytes;
`ifdef OPFETCH_PAGE_CROSS_EN
                    got_pc = page_cross;
`endif
                end
            end
            if (got_lat > 0 && c == got_lat + 1) begin
                got_busy_after = busy;
                hold_a = op_a;
            end
            @(posedge clk); #1;
            if (got_lat > 0 && c == got_lat + 1) break;
        end
        start = 1'b0;
    endtask

    task automatic check_txn(input string tag, input logic [15:0] pc, input logic [15:0] ea, input logic [15:0] eb,
                             input alu_op_t eop, input logic [1:0] eby, input int elat, input logic epc);
        logic [15:0] pc1;
        pc1 = pc + 16'd1;
        check(tag, "latency", got_lat, elat);
        check(tag, "valid_count", got_vcnt, 1);
        check(tag, "op_A", {16'h0, got_a}, {16'h0, ea});
        check(tag, "op_B", {16'h0, got_b}, {16'h0, eb});
        check(tag, "alu_op", {30'h0, got_op}, {30'h0, eop});
        check(tag, "bytes", {30'h0, got_bytes}, {30'h0, eby});
        check(tag, "op_A_hold", {16'h0, hold_a}, {16'h0, ea});
        check(tag, "busy_after", {31'h0, got_busy_after}, 32'h0);
        check(tag, "reads", rd_addr.size(), {30'h0, eby});
        if (rd_addr.size() > 0) check(tag, "addr_lo", {16'h0, rd_addr[0]}, {16'h0, pc});
        if (rd_addr.size() > 1) check(tag, "addr_hi", {16'h0, rd_addr[1]}, {16'h0, pc1});
`ifdef OPFETCH_PAGE_CROSS_EN
        check(tag, "page_cross", {31'h0, got_pc}, {31'h0, epc});
`endif
        $display("[TB] %s pc=%h A=%h B=%h op=%0d bytes=%0d lat=%0d exp_pc=%0b", tag, pc, got_a, got_b,
                 got_op, got_bytes, got_lat, epc);
    endtask

    // Reference model straight from the mode table.
    function automatic void model(input addr_mode_t m, input logic [7:0] b0, input logic [7:0] b1,
                                  input logic [7:0] x, input logic [7:0] y, input int waits,
                                  output logic [15:0] ea, output logic [15:0] eb, output alu_op_t eop,
                                  output logic [1:0] eby, output int elat, output logic epc);
        int idx;
        ea = 16'h0; eb = 16'h0; eop = ALU_BYPASS_A; eby = 2'd0; epc = 1'b0;
        case (m)
            AM_IMMEDIATE, AM_ZEROPAGE: begin ea = 16'(b0); eby = 2'd1; end
            AM_ZEROPAGE_X: begin ea = 16'(b0); eb = 16'(x); eop = ALU_ADD_ZEROPAGE; eby = 2'd1; end
            AM_ABSOLUTE: begin ea = 16'(int'(b1) * 256 + int'(b0)); eby = 2'd2; end
            AM_ABSOLUTE_X, AM_ABSOLUTE_Y: begin
                idx = (m == AM_ABSOLUTE_X) ? int'(x) : int'(y);
                ea  = 16'(int'(b1) * 256 + int'(b0));
                eb  = 16'(idx);
                eop = ALU_ADD;
                eby = 2'd2;
                epc = ((int'(b0) + idx) / 256) != 0;
            end
            default: ;
        endcase
        elat = 1 + int'(eby) * (waits + 1);
    endfunction

    typedef struct {
        addr_mode_t  mode;
        logic [15:0] pc;
        logic [7:0]  x, y, b0, b1;
        int          waits, pulse_at;
        logic [15:0] exp_a, exp_b;
        alu_op_t     exp_op;
        logic [1:0]  exp_bytes;
        int          exp_lat;
        logic        exp_pc;
    } vec_t;

    task automatic check_reset_values(input string tag);
        check(tag, "mem_req", {31'h0, mif.mem_req_o}, 32'h0);
        check(tag, "mem_addr", {16'h0, mif.mem_addr_o}, 32'h0);
        check(tag, "busy", {31'h0, busy}, 32'h0);
        check(tag, "op_valid", {31'h0, op_valid}, 32'h0);
        check(tag, "op_A", {16'h0, op_a}, 32'h0);
        check(tag, "op_B", {16'h0, op_b}, 32'h0);
        check(tag, "alu_op", {30'h0, alu_op}, {30'h0, ALU_BYPASS_A});
        check(tag, "bytes", {30'h0, nbytes}, 32'h0);
`ifdef OPFETCH_PAGE_CROSS_EN
        check(tag, "page_cross", {31'h0, page_cross}, 32'h0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [10];
        logic [15:0] ea, eb, pc, pc1;
        alu_op_t     eop;
        logic [1:0]  eby;
        int          elat, waits, vcnt;
        logic        epc;
        addr_mode_t  m;
        logic [7:0]  x, y, b0, b1;

        vecs[0] = '{AM_IMPLIED,    16'h0200, 8'h11, 8'h22, 8'hAA, 8'hBB, 0, 0, 16'h0000, 16'h0000, ALU_BYPASS_A,     2'd0, 1, 1'b0};
        vecs[1] = '{AM_IMMEDIATE,  16'h8000, 8'h00, 8'h00, 8'h5A, 8'h77, 0, 0, 16'h005A, 16'h0000, ALU_BYPASS_A,     2'd1, 2, 1'b0};
        vecs[2] = '{AM_ZEROPAGE_X, 16'h0300, 8'h20, 8'h99, 8'hF0, 8'h44, 0, 0, 16'h00F0, 16'h0020, ALU_ADD_ZEROPAGE, 2'd1, 2, 1'b0};
        vecs[3] = '{AM_ABSOLUTE_Y, 16'hFFFF, 8'h77, 8'h05, 8'h34, 8'h12, 2, 3, 16'h1234, 16'h0005, ALU_ADD,          2'd2, 7, 1'b0};
        vecs[4] = '{AM_ABSOLUTE_X, 16'h4000, 8'h01, 8'h00, 8'hFF, 8'h10, 0, 0, 16'h10FF, 16'h0001, ALU_ADD,          2'd2, 3, 1'b1};
        vecs[5] = '{AM_ABSOLUTE_X, 16'h4100, 8'h01, 8'h00, 8'h10, 8'h10, 0, 0, 16'h1010, 16'h0001, ALU_ADD,          2'd2, 3, 1'b0};
        vecs[6] = '{AM_ZEROPAGE,   16'h0010, 8'h00, 8'h00, 8'h80, 8'h01, 1, 0, 16'h0080, 16'h0000, ALU_BYPASS_A,     2'd1, 3, 1'b0};
        vecs[7] = '{AM_ABSOLUTE,   16'h2000, 8'h00, 8'h00, 8'hCD, 8'hAB, 0, 0, 16'hABCD, 16'h0000, ALU_BYPASS_A,     2'd2, 3, 1'b0};
        vecs[8] = '{addr_mode_t'(3'd7), 16'h1234, 8'h01, 8'h02, 8'h03, 8'h04, 0, 0, 16'h0000, 16'h0000, ALU_BYPASS_A, 2'd0, 1, 1'b0};
        vecs[9] = '{AM_IMMEDIATE,  16'h0000, 8'h00, 8'h00, 8'h01, 8'h02, 3, 0, 16'h0001, 16'h0000, ALU_BYPASS_A,     2'd1, 5, 1'b0};

        #12;
        check_reset_values("reset");
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            pc1 = vecs[i].pc + 16'd1;
            mem_arr[vecs[i].pc] = vecs[i].b0;
            mem_arr[pc1] = vecs[i].b1;
            run_txn(vecs[i].mode, vecs[i].pc, vecs[i].x, vecs[i].y, vecs[i].waits, vecs[i].pulse_at);
            check_txn($sformatf("vec%0d", i), vecs[i].pc, vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_op,
                      vecs[i].exp_bytes, vecs[i].exp_lat, vecs[i].exp_pc);
        end

        // Reset while the high byte is being fetched abandons the transaction.
        mem_arr[16'h1000] = 8'h11;
        mem_arr[16'h1001] = 8'h22;
        wait_cfg = 3;
        start = 1'b1; mode_in = AM_ABSOLUTE; pc_in = 16'h1000;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
        end
        check("rst_mid", "req_in_hi", {31'h0, mif.mem_req_o}, 32'h1);
        check("rst_mid", "addr_in_hi", {16'h0, mif.mem_addr_o}, 32'h1001);
        rstn = 1'b0;
        #1;
        check_reset_values("rst_mid");
        @(posedge clk); @(posedge clk);
        @(negedge clk); rstn = 1'b1;
        vcnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (op_valid) vcnt++;
        end
        check("rst_mid", "stray_valid", vcnt, 0);
        check("rst_mid", "busy_idle", {31'h0, busy}, 32'h0);
        $display("[TB] rst_mid reset during FETCH_HI, stray valids=%0d", vcnt);
        @(posedge clk); #1;
        run_txn(AM_ABSOLUTE, 16'h1000, 8'h00, 8'h00, 0, 0);
        check_txn("after_rst", 16'h1000, 16'h2211, 16'h0000, ALU_BYPASS_A, 2'd2, 3, 1'b0);

        for (int i = 0; i < 120; i++) begin
            m  = addr_mode_t'(3'($urandom_range(0, 7)));
            pc = (i % 10 == 0) ? 16'hFFFF : 16'($urandom);
            x  = 8'($urandom); y = 8'($urandom);
            b0 = 8'($urandom); b1 = 8'($urandom);
            waits = int'($urandom_range(0, 3));
            spur = 1'($urandom);
            junk = 8'($urandom);
            pc1 = pc + 16'd1;
            mem_arr[pc] = b0;
            mem_arr[pc1] = b1;
            model(m, b0, b1, x, y, waits, ea, eb, eop, eby, elat, epc);
            run_txn(m, pc, x, y, waits, int'($urandom_range(0, elat)));
            check_txn($sformatf("rnd%0d", i), pc, ea, eb, eop, eby, elat, epc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
